uart_frame_ctrl: RTL and testbench
==================================

UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 100000: idle cycles allowed between bytes inside a frame.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port rx_data, input, 8: received byte.
REQ-005 SHALL have port rx_valid, input, 1: one-cycle strobe per received byte.
REQ-006 SHALL have port rx_err, input, 1: parity/frame error qualifier for the byte on rx_valid.
REQ-007 SHALL have ports x_out, y_out, z_out, output, 32 each: decoded fixed-point words.
REQ-008 SHALL have port out_valid, output, 1: triplet available; held until accepted.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts when out_valid && out_ready.
REQ-010 SHALL have port err_pulse, output, 1, and err_code, output, 3: one-cycle error report.
REQ-011 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-012 SHALL use frame format '$'(0x24), 24 hex chars (x MSB nibble first, then y, then z), terminator 0x0A.
REQ-013 SHALL accept hex digits '0'-'9', 'A'-'F' and 'a'-'f' only. Any other byte in DATA is BADCHAR.
REQ-014 SHALL implement states IDLE, DATA, TERM and HOLD, plus CKSUM when the macro is defined.
- IDLE: wait for '$'; all other bytes are ignored.
- DATA: shift in nibbles; move to CKSUM (or TERM) after the 24th nibble.
- TERM: 0x0A moves to HOLD; any other byte is error TERM.
- HOLD: wait for the handshake.
REQ-015 SHALL load x_out/y_out/z_out and assert out_valid on the cycle after the terminator byte is strobed.
REQ-016 SHALL leave output words unchanged until the next successful frame. Partial frames SHALL NOT alter them.
REQ-017 SHALL deassert out_valid and return to IDLE on the cycle after out_valid && out_ready.
REQ-018 SHALL discard any byte strobed in HOLD and report OVERRUN.
REQ-019 SHALL treat '$' received in DATA/TERM/CKSUM as a resync: restart at nibble 0 with no error.
REQ-020 SHALL report RXERR when rx_err is high with rx_valid in any state except IDLE and HOLD, then return to IDLE. In IDLE, such a byte is ignored.
REQ-021 SHALL count cycles without rx_valid in DATA/TERM/CKSUM. On reaching TIMEOUT_CYC it SHALL report TIMEOUT and return to IDLE.
REQ-022 SHALL give rx_valid precedence over the timeout when both occur in the same cycle; the counter then clears.
REQ-023 SHALL use err_code values: 1 BADCHAR, 2 TERM, 3 TIMEOUT, 4 RXERR, 5 OVERRUN, 6 CKSUM, 0 none.
REQ-024 SHALL raise err_pulse for exactly one cycle per error. Every error except OVERRUN SHALL return the block to IDLE.
REQ-025 SHALL use a nibble counter of 5 bits covering 0..23, cleared on every return to IDLE.

Reset
REQ-026 SHALL on rst set the state to IDLE and clear x_out, y_out, z_out, out_valid, err_pulse, err_code, busy, the counters and the checksum.
REQ-027 SHALL abandon any frame in progress on rst, including HOLD; no error is reported.

Configuration
REQ-028 SHALL use macro UART_FRAME_CKSUM_EN.
- Defined: two hex chars follow the 24 data chars. They SHALL equal the XOR of the 12 data bytes, where each data byte is a pair of consecutive data nibbles. A mismatch reports CKSUM.
- Undefined: the CKSUM state and checksum logic are absent; TERM follows DATA directly.

Structure
REQ-029 SHALL take the following from shared package uart_pkg:
- state enum
- ASCII constants ('$', LF)
- err_code constants
- frame length (24)
REQ-030 SHALL instantiate sub-module uart_hex_dec: combinational byte -> {is_hex, nibble[3:0]}.

Verification
REQ-031 SHALL cover: "$0001000000020000FFFF8000\n" -> x=0x00010000, y=0x00020000, z=0xFFFF8000, out_valid=1 one cycle after LF.
REQ-032 SHALL cover: 'G' as 5th data char -> err_pulse, err_code=1, state IDLE, previous outputs unchanged.
REQ-033 SHALL cover: valid frame with out_ready=0 then 3 extra bytes -> three err_code=5 pulses; outputs held; release after out_ready=1.
REQ-034 SHALL cover, with TIMEOUT_CYC=16: 10 chars then silence -> err_code=3 on idle cycle 16; busy=0.
REQ-035 SHALL cover: '$' mid-frame followed by a full frame -> second frame decoded, no err_pulse.
REQ-036 SHALL cover, with UART_FRAME_CKSUM_EN: correct checksum -> out_valid; checksum off by one -> err_code=6, out_valid stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_TERM,
        ST_HOLD
`ifdef UART_FRAME_CKSUM_EN
        , ST_CKSUM
`endif
    } state_t;

    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_LF     = 8'h0A;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_BADCHAR = 3'd1;
    localparam logic [2:0] ERR_TERM    = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_RXERR   = 3'd4;
    localparam logic [2:0] ERR_OVERRUN = 3'd5;
    localparam logic [2:0] ERR_CKSUM   = 3'd6;

    localparam int FRAME_NIBS = 24;

`ifdef UART_FRAME_CKSUM_EN
    // XOR of the twelve bytes formed by consecutive nibble pairs of the payload.
    function automatic logic [7:0] xor_bytes(input logic [95:0] d);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 12; i++) begin
            acc = acc ^ d[i*8 +: 8];
        end
        return acc;
    endfunction
`endif

endpackage

// File: rtl/uart_hex_dec.sv
// ASCII hex digit decoder: byte -> {is_hex, nibble}, accepts 0-9, A-F, a-f.
// Latency: combinational.
// Backpressure: none.
module uart_hex_dec (
    input  logic [7:0] rx_byte,
    output logic       is_hex,
    output logic [3:0] nibble
);

    always_comb begin
        is_hex = 1'b0;
        nibble = 4'h0;
        if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
            is_hex = 1'b1;
            nibble = rx_byte[3:0];
        end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                     (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
            is_hex = 1'b1;
            nibble = rx_byte[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Parses '$' + 24 hex chars (+2 checksum chars with UART_FRAME_CKSUM_EN) + LF into x/y/z words.
// Latency: words and out_valid appear the cycle after the LF strobe; errors pulse the cycle after the byte.
// Backpressure: out_valid holds until out_ready; bytes arriving while held are dropped and flagged OVERRUN.
module uart_frame_ctrl
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_err,
    output logic [31:0] x_out,
    output logic [31:0] y_out,
    output logic [31:0] z_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err_pulse,
    output logic [2:0]  err_code,
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t        state, state_nxt;
    logic [4:0]    nib_cnt, nib_nxt;
    logic [95:0]   sh, sh_nxt;
    logic [TW-1:0] idle_cnt, idle_nxt;
    logic [31:0]   x_nxt, y_nxt, z_nxt;
    logic          ov_nxt, err_nxt;
    logic [2:0]    code_nxt;
    logic          is_hex;
    logic [3:0]    nib;
    logic          active;
`ifdef UART_FRAME_CKSUM_EN
    logic [3:0]    ck_nib, ck_nxt;
`endif

    uart_hex_dec u_hex_dec (
        .rx_byte (rx_data),
        .is_hex  (is_hex),
        .nibble  (nib)
    );

    assign busy = (state != ST_IDLE);

`ifdef UART_FRAME_CKSUM_EN
    assign active = (state == ST_DATA) || (state == ST_TERM) || (state == ST_CKSUM);
`else
    assign active = (state == ST_DATA) || (state == ST_TERM);
`endif

    always_comb begin
        state_nxt = state;
        nib_nxt   = nib_cnt;
        sh_nxt    = sh;
        idle_nxt  = idle_cnt;
        x_nxt     = x_out;
        y_nxt     = y_out;
        z_nxt     = z_out;
        ov_nxt    = out_valid;
        err_nxt   = 1'b0;
        code_nxt  = ERR_NONE;
`ifdef UART_FRAME_CKSUM_EN
        ck_nxt    = ck_nib;
`endif

        // A strobe always wins over the timeout and restarts the idle count.
        if (active) begin
            if (rx_valid) begin
                idle_nxt = '0;
            end else if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
                err_nxt   = 1'b1;
                code_nxt  = ERR_TIMEOUT;
                state_nxt = ST_IDLE;
            end else begin
                idle_nxt = idle_cnt + 1'b1;
            end
        end

        unique case (state)
            ST_IDLE: begin
                if (rx_valid && !rx_err && rx_data == ASCII_DOLLAR) begin
                    state_nxt = ST_DATA;
                    nib_nxt   = 5'd0;
                end
            end
            ST_HOLD: begin
                if (rx_valid) begin
                    err_nxt  = 1'b1;
                    code_nxt = ERR_OVERRUN;
                end
                if (out_valid && out_ready) begin
                    ov_nxt    = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                if (rx_valid) begin
                    if (rx_err) begin
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_RXERR;
                        state_nxt = ST_IDLE;
                    end else if (rx_data == ASCII_DOLLAR) begin
                        state_nxt = ST_DATA;
                        nib_nxt   = 5'd0;
                    end else if (state == ST_DATA) begin
                        if (is_hex) begin
                            sh_nxt = {sh[91:0], nib};
                            if (nib_cnt == 5'(FRAME_NIBS - 1)) begin
                                nib_nxt = 5'd0;
`ifdef UART_FRAME_CKSUM_EN
                                state_nxt = ST_CKSUM;
`else
                                state_nxt = ST_TERM;
`endif
                            end else begin
                                nib_nxt = nib_cnt + 5'd1;
                            end
                        end else begin
                            err_nxt   = 1'b1;
                            code_nxt  = ERR_BADCHAR;
                            state_nxt = ST_IDLE;
                        end
`ifdef UART_FRAME_CKSUM_EN
                    end else if (state == ST_CKSUM) begin
                        if (!is_hex) begin
                            err_nxt   = 1'b1;
                            code_nxt  = ERR_BADCHAR;
                            state_nxt = ST_IDLE;
                        end else if (nib_cnt == 5'd0) begin
                            ck_nxt  = nib;
                            nib_nxt = 5'd1;
                        end else if ({ck_nib, nib} == xor_bytes(sh)) begin
                            nib_nxt   = 5'd0;
                            state_nxt = ST_TERM;
                        end else begin
                            err_nxt   = 1'b1;
                            code_nxt  = ERR_CKSUM;
                            state_nxt = ST_IDLE;
                        end
`endif
                    end else if (rx_data == ASCII_LF) begin
                        x_nxt     = sh[95:64];
                        y_nxt     = sh[63:32];
                        z_nxt     = sh[31:0];
                        ov_nxt    = 1'b1;
                        state_nxt = ST_HOLD;
                    end else begin
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_TERM;
                        state_nxt = ST_IDLE;
                    end
                end
            end
        endcase

        if (state_nxt == ST_IDLE) begin
            nib_nxt  = 5'd0;
            idle_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            nib_cnt   <= 5'd0;
            sh        <= '0;
            idle_cnt  <= '0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
            out_valid <= 1'b0;
            err_pulse <= 1'b0;
            err_code  <= ERR_NONE;
`ifdef UART_FRAME_CKSUM_EN
            ck_nib    <= 4'h0;
`endif
        end else begin
            state     <= state_nxt;
            nib_cnt   <= nib_nxt;
            sh        <= sh_nxt;
            idle_cnt  <= idle_nxt;
            x_out     <= x_nxt;
            y_out     <= y_nxt;
            z_out     <= z_nxt;
            out_valid <= ov_nxt;
            err_pulse <= err_nxt;
            err_code  <= code_nxt;
`ifdef UART_FRAME_CKSUM_EN
            ck_nib    <= ck_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl with TIMEOUT_CYC=16; checksum vectors run when UART_FRAME_CKSUM_EN is defined.
module tb_uart_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_err;
    logic [31:0] x_out, y_out, z_out;
    logic        out_valid;
    logic        out_ready;
    logic        err_pulse;
    logic [2:0]  err_code;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int err_seen = 0;
    int e0;

    always #5 clk = ~clk;

    uart_frame_ctrl #(.TIMEOUT_CYC(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_err    (rx_err),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_pulse (err_pulse),
        .err_code  (err_code),
        .busy      (busy)
    );

    always @(negedge clk) if (err_pulse) err_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        rx_err   = 1'b0;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_err(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        rx_err   = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_err   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

`ifdef UART_FRAME_CKSUM_EN
    function automatic logic [3:0] hexv(input logic [7:0] c);
        return (c <= 8'h39) ? c[3:0] : (c[3:0] + 4'd9);
    endfunction

    function automatic logic [7:0] frame_ck(input string s);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 24; i += 2) acc = acc ^ {hexv(s[i]), hexv(s[i+1])};
        return acc;
    endfunction
`endif

    // '$' + payload (+ correct checksum when enabled); terminator left to the caller.
    task automatic send_frame(input string s);
`ifdef UART_FRAME_CKSUM_EN
        logic [7:0] ck;
        ck = frame_ck(s);
`endif
        send(8'h24);
        send_str(s);
`ifdef UART_FRAME_CKSUM_EN
        send(hexc(ck[7:4]));
        send(hexc(ck[3:0]));
`endif
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_err = 1'b0; out_ready = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
        check("rst_err_code", {29'd0, err_code}, 32'd0);
        check("rst_x", x_out, 32'd0);
        check("rst_z", z_out, 32'd0);

        // basic frame
        send_frame("0001000000020000FFFF8000");
        check("a_pre_lf_valid", {31'd0, out_valid}, 32'd0);
        check("a_pre_lf_busy", {31'd0, busy}, 32'd1);
        send(8'h0A);
        check("a_valid", {31'd0, out_valid}, 32'd1);
        check("a_x", x_out, 32'h00010000);
        check("a_y", y_out, 32'h00020000);
        check("a_z", z_out, 32'hFFFF8000);
        check("a_no_err", {31'd0, err_pulse}, 32'd0);
        handshake();
        check("a_release_valid", {31'd0, out_valid}, 32'd0);
        check("a_release_busy", {31'd0, busy}, 32'd0);

        // bad character as 5th data char
        send(8'h24);
        send_str("0001");
        send("G");
        check("bad_pulse", {31'd0, err_pulse}, 32'd1);
        check("bad_code", {29'd0, err_code}, 32'd1);
        check("bad_busy", {31'd0, busy}, 32'd0);
        check("bad_x_held", x_out, 32'h00010000);
        check("bad_z_held", z_out, 32'hFFFF8000);
        idle(1);
        check("bad_one_cycle", {31'd0, err_pulse}, 32'd0);

        // overrun while holding, lowercase digits
        send_frame("12345678abcdefABDEADBEEF");
        send(8'h0A);
        check("b_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            send("Z");
            check("ovr_pulse", {31'd0, err_pulse}, 32'd1);
            check("ovr_code", {29'd0, err_code}, 32'd5);
            check("ovr_valid", {31'd0, out_valid}, 32'd1);
        end
        idle(1);
        check("ovr_pulse_end", {31'd0, err_pulse}, 32'd0);
        check("b_x", x_out, 32'h12345678);
        check("b_y", y_out, 32'hABCDEFAB);
        check("b_z", z_out, 32'hDEADBEEF);
        handshake();
        check("b_release", {31'd0, out_valid}, 32'd0);

        // resync on '$' mid-frame
        e0 = err_seen;
        send(8'h24);
        send_str("0123");
        send_frame("CAFEF00D000000017FFFFFFF");
        send(8'h0A);
        check("c_valid", {31'd0, out_valid}, 32'd1);
        check("c_x", x_out, 32'hCAFEF00D);
        check("c_y", y_out, 32'h00000001);
        check("c_z", z_out, 32'h7FFFFFFF);
        check("c_no_err", err_seen - e0, 32'd0);
        handshake();

        // wrong terminator
        send_frame("0001000000020000FFFF8000");
        send("X");
        check("term_pulse", {31'd0, err_pulse}, 32'd1);
        check("term_code", {29'd0, err_code}, 32'd2);
        check("term_valid", {31'd0, out_valid}, 32'd0);
        check("term_x_held", x_out, 32'hCAFEF00D);

        // rx_err in DATA, then ignored in IDLE
        send(8'h24);
        send("1");
        send_err("2");
        check("rxerr_code", {29'd0, err_code}, 32'd4);
        check("rxerr_busy", {31'd0, busy}, 32'd0);
        send_err(8'h24);
        check("rxerr_idle_busy", {31'd0, busy}, 32'd0);
        check("rxerr_idle_pulse", {31'd0, err_pulse}, 32'd0);

        // timeout after 10 chars
        send(8'h24);
        send_str("012345678");
        idle(15);
        check("to_15_pulse", {31'd0, err_pulse}, 32'd0);
        check("to_15_busy", {31'd0, busy}, 32'd1);
        idle(1);
        check("to_16_pulse", {31'd0, err_pulse}, 32'd1);
        check("to_16_code", {29'd0, err_code}, 32'd3);
        check("to_16_busy", {31'd0, busy}, 32'd0);

        // byte on idle cycle 16 beats the timeout
        send(8'h24);
        idle(15);
        send("A");
        check("prec_pulse", {31'd0, err_pulse}, 32'd0);
        check("prec_busy", {31'd0, busy}, 32'd1);
        idle(15);
        check("prec_15_pulse", {31'd0, err_pulse}, 32'd0);
        idle(1);
        check("prec_16_code", {29'd0, err_code}, 32'd3);

`ifdef UART_FRAME_CKSUM_EN
        send(8'h24);
        send_str("0001000000020000FFFF8000");
        send("8");
        send("3");
        send(8'h0A);
        check("ck_good_valid", {31'd0, out_valid}, 32'd1);
        check("ck_good_x", x_out, 32'h00010000);
        handshake();
        send(8'h24);
        send_str("0001000000020000FFFF8000");
        send("8");
        send("4");
        check("ck_bad_pulse", {31'd0, err_pulse}, 32'd1);
        check("ck_bad_code", {29'd0, err_code}, 32'd6);
        check("ck_bad_busy", {31'd0, busy}, 32'd0);
        send(8'h0A);
        check("ck_bad_valid", {31'd0, out_valid}, 32'd0);
`endif

        // reset abandons HOLD without error
        send_frame("12345678abcdefABDEADBEEF");
        send(8'h0A);
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("hold_rst_valid", {31'd0, out_valid}, 32'd0);
        check("hold_rst_x", x_out, 32'd0);
        check("hold_rst_busy", {31'd0, busy}, 32'd0);
        check("hold_rst_pulse", {31'd0, err_pulse}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
